// File: rtl/opb_reg_pkg.sv
// Shared constants, types and helpers for the OPB software-register slaves.
// Word offsets, ack FSM encoding, bus tie-offs and byte-lane merge.
package opb_reg_pkg;

  localparam logic [1:0] OFF_DATA  = 2'd0;
  localparam logic [1:0] OFF_COUNT = 2'd1;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } ack_state_e;

  localparam logic SL_ERRACK_TIE  = 1'b0;
  localparam logic SL_RETRY_TIE   = 1'b0;
  localparam logic SL_TOUTSUP_TIE = 1'b0;

  // OPB numbering: byte lane i is bits [8i:8i+7], lane 0 is the most significant.
  function automatic logic [0:31] merge_bytes(input logic [0:31] cur,
                                              input logic [0:31] wdat,
                                              input logic [0:3]  be);
    logic [0:31] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdat[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/opb_register_ppc2simulink_if.sv
// OPB slave-side signal bundle, kept in OPB bit numbering ([0] = MSB).
interface opb_register_ppc2simulink_if #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32
);
  import opb_reg_pkg::*;

  logic [0:C_OPB_AWIDTH-1]   OPB_ABus;
  logic [0:C_OPB_DWIDTH/8-1] OPB_BE;
  logic [0:C_OPB_DWIDTH-1]   OPB_DBus;
  logic                      OPB_RNW;
  logic                      OPB_select;
  logic                      OPB_seqAddr;
  logic [0:C_OPB_DWIDTH-1]   Sl_DBus;
  logic                      Sl_xferAck;
  logic                      Sl_errAck;
  logic                      Sl_retry;
  logic                      Sl_toutSup;

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

endinterface

// File: rtl/opb_slave_ack_ctrl.sv
// Address decode and single-cycle ack FSM shared by the OPB register slaves.
//   state | meaning
//   IDLE  | waiting for a selected transfer inside the window
//   ACK   | Sl_xferAck high for this one cycle, then back to IDLE
module opb_slave_ack_ctrl
  import opb_reg_pkg::*;
#(
  parameter int                      C_OPB_AWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h0108_2000,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h0108_20FF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [0:C_OPB_AWIDTH-1] abus,
  input  logic                    select,
  output logic                    hit_commit,
  output logic [1:0]              word_idx,
  output logic                    ack
);

  ack_state_e state_q, state_d;
  logic       hit;

  assign hit      = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign word_idx = abus[C_OPB_AWIDTH-4 +: 2];
  assign ack      = (state_q == ACK);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Leaving IDLE on a hit is the commit edge; ACK always returns to IDLE so
  // back-to-back acks are impossible.
  always_comb begin
    state_d    = state_q;
    hit_commit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d    = ACK;
          hit_commit = 1'b1;
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// PowerPC-to-fabric software register: OPB-writable data word plus a
// read-only count of committed data writes.
module opb_register_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0108_2000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0108_20FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [31:0] C_INIT       = 32'h0000_0000,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                          OPB_Clk,
  input  logic                          OPB_Rst,
  opb_register_ppc2simulink_if.slave    bus,
  output logic [31:0]                   user_data_out,
  output logic                          user_data_valid
);

  localparam int unused_family_bits = $bits(C_FAMILY);

  logic [0:31] data_q;
  logic [31:0] count_q;
  logic [0:31] sl_dbus_q;
  logic        valid_q;
  logic        hit_commit;
  logic [1:0]  word_idx;
  logic        ack;
  logic        data_wr;
  logic [0:31] rd_word;
  logic        unused_ok;

  assign unused_ok = &{1'b0, bus.OPB_seqAddr};

  opb_slave_ack_ctrl #(
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_BASEADDR   (C_BASEADDR[C_OPB_AWIDTH-1:0]),
    .C_HIGHADDR   (C_HIGHADDR[C_OPB_AWIDTH-1:0])
  ) u_ack_ctrl (
    .clk        (OPB_Clk),
    .rst        (OPB_Rst),
    .abus       (bus.OPB_ABus),
    .select     (bus.OPB_select),
    .hit_commit (hit_commit),
    .word_idx   (word_idx),
    .ack        (ack)
  );

  // An all-zero byte enable still gets acked but must not count as a write.
  assign data_wr = hit_commit && !bus.OPB_RNW && (word_idx == OFF_DATA) && (|bus.OPB_BE);

  always_comb begin
    rd_word = '0;
    unique case (word_idx)
      OFF_DATA:  rd_word = data_q;
      OFF_COUNT: rd_word = count_q;
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      data_q    <= C_INIT;
      count_q   <= '0;
      sl_dbus_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      sl_dbus_q <= '0;
      if (data_wr) begin
        data_q  <= merge_bytes(data_q, bus.OPB_DBus, bus.OPB_BE);
        count_q <= count_q + 32'd1;
        valid_q <= 1'b1;
      end
      if (hit_commit && bus.OPB_RNW) sl_dbus_q <= rd_word;
    end
  end

  assign bus.Sl_DBus    = sl_dbus_q;
  assign bus.Sl_xferAck = ack;
  assign bus.Sl_errAck  = SL_ERRACK_TIE;
  assign bus.Sl_retry   = SL_RETRY_TIE;
  assign bus.Sl_toutSup = SL_TOUTSUP_TIE;

  assign user_data_out   = data_q;
  assign user_data_valid = valid_q;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Directed-vector bench for opb_register_ppc2simulink.
module tb_opb_register_ppc2simulink;

  localparam logic [31:0] INIT = 32'hA5A5_0000;
  localparam logic [31:0] BASE = 32'h0108_2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] user_data_out;
  logic        user_data_valid;
  int          n_vec  = 0;
  int          n_miss = 0;

  opb_register_ppc2simulink_if bus ();

  opb_register_ppc2simulink #(.C_INIT(INIT)) dut (
    .OPB_Clk         (clk),
    .OPB_Rst         (rst),
    .bus             (bus),
    .user_data_out   (user_data_out),
    .user_data_valid (user_data_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive one transfer for 'hold' sampled edges, then one idle edge; record bus activity.
  task automatic xfer(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdat,
                      input logic rnw, input int hold,
                      output int acks, output int first_ack, output int valids,
                      output logic [31:0] rdata, output int leak);
    acks = 0; first_ack = 0; valids = 0; rdata = '0; leak = 0;
    @(negedge clk);
    bus.OPB_ABus = addr; bus.OPB_BE = be; bus.OPB_DBus = wdat;
    bus.OPB_RNW = rnw; bus.OPB_select = 1'b1;
    for (int c = 1; c <= hold + 1; c++) begin
      if (c == hold + 1) begin
        @(negedge clk);
        bus.OPB_select = 1'b0; bus.OPB_BE = '0; bus.OPB_DBus = '0; bus.OPB_RNW = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.Sl_xferAck) begin
        acks++;
        if (first_ack == 0) first_ack = c;
        rdata = bus.Sl_DBus;
      end else if (bus.Sl_DBus != '0) begin
        leak++;
      end
      if (user_data_valid) valids++;
    end
  endtask

  int          acks, first_ack, valids, leak;
  logic [31:0] rdata;

  initial begin
    bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0;
    bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_data",  user_data_out, INIT);
    chk("rst_ack",   32'(bus.Sl_xferAck), 32'd0);
    chk("rst_dbus",  bus.Sl_DBus, 32'd0);
    chk("rst_valid", 32'(user_data_valid), 32'd0);
    chk("tieoffs",   {29'd0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'd0);

    xfer(BASE, 4'b1111, 32'hDEAD_BEEF, 1'b0, 2, acks, first_ack, valids, rdata, leak);
    chk("wr_full_acks",  32'(acks), 32'd1);
    chk("wr_full_first", 32'(first_ack), 32'd1);
    chk("wr_full_valid", 32'(valids), 32'd1);
    chk("wr_full_data",  user_data_out, 32'hDEAD_BEEF);
    xfer(BASE + 32'h4, 4'b1111, '0, 1'b1, 2, acks, first_ack, valids, rdata, leak);
    chk("cnt_after_1", rdata, 32'd1);

    xfer(BASE, 4'b0100, 32'h0033_0000, 1'b0, 2, acks, first_ack, valids, rdata, leak);
    chk("wr_byte_data",  user_data_out, 32'hDE33_BEEF);
    chk("wr_byte_valid", 32'(valids), 32'd1);
    xfer(BASE, 4'b0000, 32'hFFFF_FFFF, 1'b0, 2, acks, first_ack, valids, rdata, leak);
    chk("wr_be0_acks",  32'(acks), 32'd1);
    chk("wr_be0_data",  user_data_out, 32'hDE33_BEEF);
    chk("wr_be0_valid", 32'(valids), 32'd0);
    xfer(BASE + 32'h4, 4'b1111, 32'h0000_0055, 1'b0, 2, acks, first_ack, valids, rdata, leak);
    chk("wr_cnt_acks", 32'(acks), 32'd1);
    xfer(BASE + 32'h4, 4'b1111, '0, 1'b1, 2, acks, first_ack, valids, rdata, leak);
    chk("cnt_after_3", rdata, 32'd2);

    xfer(BASE, 4'b1111, '0, 1'b1, 2, acks, first_ack, valids, rdata, leak);
    chk("rd_data",      rdata, 32'hDE33_BEEF);
    chk("rd_data_acks", 32'(acks), 32'd1);
    chk("rd_data_leak", 32'(leak), 32'd0);
    chk("rd_unchanged", user_data_out, 32'hDE33_BEEF);
    xfer(BASE + 32'h8, 4'b1111, '0, 1'b1, 2, acks, first_ack, valids, rdata, leak);
    chk("rd_w2_acks", 32'(acks), 32'd1);
    chk("rd_w2_data", rdata, 32'd0);
    xfer(32'h0108_3000, 4'b1111, '0, 1'b1, 2, acks, first_ack, valids, rdata, leak);
    chk("rd_miss_acks", 32'(acks), 32'd0);
    chk("rd_miss_leak", 32'(leak), 32'd0);

    @(negedge clk);
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    xfer(BASE, 4'b1111, 32'h1122_3344, 1'b0, 2, acks, first_ack, valids, rdata, leak);
    chk("wrap_data", user_data_out, 32'h1122_3344);
    xfer(BASE + 32'h4, 4'b1111, '0, 1'b1, 2, acks, first_ack, valids, rdata, leak);
    chk("wrap_count", rdata, 32'd0);

    @(negedge clk);
    bus.OPB_ABus = BASE; bus.OPB_BE = 4'b1111; bus.OPB_DBus = 32'h1234_5678;
    bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_ack",   32'(bus.Sl_xferAck), 32'd0);
    chk("rstmid_valid", 32'(user_data_valid), 32'd0);
    chk("rstmid_data",  user_data_out, INIT);
    @(negedge clk);
    rst = 1'b0; bus.OPB_select = 1'b0;
    xfer(BASE, 4'b1111, 32'hCAFE_F00D, 1'b0, 2, acks, first_ack, valids, rdata, leak);
    chk("post_rst_data",  user_data_out, 32'hCAFE_F00D);
    chk("post_rst_valid", 32'(valids), 32'd1);
    xfer(BASE + 32'h4, 4'b1111, '0, 1'b1, 2, acks, first_ack, valids, rdata, leak);
    chk("post_rst_count", rdata, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/opb_register_ppc2simulink.md
Name: opb_register_ppc2simulink

Overview:
OPB slave software register that carries data in the opposite direction to the simulink2ppc snapshot/address registers: the PowerPC writes a 32-bit value over OPB and the user fabric reads it. A write-count word is also readable for software sanity checks. It sits on the shared OPB alongside the other register slaves. Single clock domain: user logic runs on OPB_Clk.

Parameters:
C_BASEADDR, 32'h01082000, first byte address of the slave window
C_HIGHADDR, 32'h010820FF, last byte address of the slave window
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width
C_INIT, 32'h00000000, reset value of the data register
C_FAMILY, "virtex5", target family string (informational)

Ports:
OPB_Clk  in  1  bus and user clock
OPB_Rst  in  1  synchronous active-high reset
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables; BE[0] qualifies DBus[0:7]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1=read, 0=write
OPB_select  in  1  transfer in progress
OPB_seqAddr  in  1  sequential hint (ignored)
Sl_DBus  out  [0:31]  read data, zero unless acking a read
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
user_data_out  out  [31:0]  current register value; user_data_out[31-i] = reg bit i (OPB numbering)
user_data_valid  out  1  one-cycle pulse when the register has just been written

Behaviour:
- Interface: one clock, OPB_Clk; reset OPB_Rst is synchronous and active-high.
- Hit = OPB_select & C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- Offset = OPB_ABus[28:29] (word index).
  - Word 0 (0x0): data register, R/W.
  - Word 1 (0x4): write count, RO, 32-bit.
  - Other words: acked; writes ignored; reads return 0.
- Ack FSM, two states:
  - IDLE -> ACK when Hit and Sl_xferAck=0.
  - ACK -> IDLE unconditionally.
  - Sl_xferAck is high in exactly the ACK cycle, i.e. one cycle after select is first sampled.
  - Consequences: no back-to-back acks, and single-cycle acks for a select held longer.
- Write (RNW=0, word 0), committed on the edge that enters ACK:
  - Each byte i with BE[i]=1 is loaded from DBus[8i:8i+7]; other bytes hold.
  - user_data_valid=1 and count+1 during the ACK cycle.
  - BE=4'b0000: acked, no update, no valid pulse, no count increment.
- Writes to word 1 are acked and ignored.
- Count wraps 0xFFFFFFFF -> 0 with no flag.
- Read: Sl_DBus is loaded on the same edge, so read data is valid during the ACK cycle and zero in all other cycles (wired-OR bus rule).
- Read of word 0 returns the register value as of the cycle before ACK.
- Timing: user_data_out changes only on write commits; latency from first sampled select to new value visible is 1 cycle.
- Select deasserted before ACK (master abort): FSM stays IDLE, no update.
- Reset values: Sl_xferAck=0, Sl_DBus=0, user_data_valid=0, register=C_INIT, count=0, FSM=IDLE.
- Reset asserted during ACK: all of the above on the next edge; the in-flight write is lost if reset coincides with the commit edge (reset dominates).

Decomposition:
- Package opb_reg_pkg:
  - word offset constants OFF_DATA=0, OFF_COUNT=1
  - ack FSM state enum {IDLE, ACK}
  - OPB tie-off constants
- Sub-module opb_slave_ack_ctrl: address decode plus ack FSM. Outputs hit_commit, word_idx, ack. Reusable by the other register slaves.
- Top level holds the data/count registers, byte-lane muxing and read mux.

Test Plan:
- Reset: hold OPB_Rst 2 cycles with C_INIT=32'hA5A5_0000 -> user_data_out=A5A50000, Sl_xferAck=0, Sl_DBus=0, valid=0.
- Full write: ABus=0x01082000, BE=1111, DBus=0xDEADBEEF, select held 3 cycles -> one ack at cycle +1; user_data_out=DEADBEEF and valid=1 for that cycle only; count read at 0x4 returns 1.
- Byte write: from DEADBEEF, BE=0100, DBus=0x00330000 -> register=DE33BEEF. Then BE=0000 -> acked, value unchanged, no valid pulse, count unchanged.
- Readback: read 0x01082000 -> Sl_DBus=DE33BEEF only in the ack cycle, 0 otherwise. Read 0x01082008 -> acked with 0. Read 0x01083000 (miss) -> no ack, Sl_DBus stays 0.
- Count wrap: force count to 0xFFFFFFFF, perform one write -> count reads 0x00000000.
- Reset mid-transfer: assert OPB_Rst on the commit edge of a write of 0x12345678 -> register=C_INIT, no ack, no valid. The next write after reset completes normally.
